// File: rtl/shift_unit_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_seq
// Brief    : Multi-cycle shifter (SLL/SRL/SRA/ROL), one barrel stage per clock,
//            start/ready handshake matching the multdiv unit.
// Revision : 1.0 - initial release
// ============================================================================
module shift_unit_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_shift,
    input  logic [1:0]         ctrl_shiftOp,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    localparam logic [1:0] c_OP_SLL = 2'b00;
    localparam logic [1:0] c_OP_SRL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b10;

    localparam logic [SHAMT_W-1:0] c_LAST_K = SHAMT_W'(SHAMT_W - 1);

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_amt;
    logic [1:0]         r_op;
    logic [SHAMT_W-1:0] r_k;
    logic [WIDTH-1:0]   r_result;
    logic               r_rdy;

    logic [WIDTH-1:0]   w_stage [SHAMT_W];
    logic [WIDTH-1:0]   w_next;

    // Fixed-distance candidates for every stage; only the one for r_k is used.
    generate
        for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
            localparam int c_DIST = 2 ** g;
            assign w_stage[g] =
                (r_op == c_OP_SLL) ? {r_work[WIDTH-1-c_DIST:0], {c_DIST{1'b0}}} :
                (r_op == c_OP_SRL) ? {{c_DIST{1'b0}}, r_work[WIDTH-1:c_DIST]} :
                (r_op == c_OP_SRA) ? {{c_DIST{r_work[WIDTH-1]}}, r_work[WIDTH-1:c_DIST]} :
                                     {r_work[WIDTH-1-c_DIST:0], r_work[WIDTH-1:WIDTH-c_DIST]};
        end
    endgenerate

    always_comb begin
        w_next = r_work;
        for (int i = 0; i < SHAMT_W; i++) begin
            if ((r_k == SHAMT_W'(i)) && r_amt[i]) begin
                w_next = w_stage[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_work   <= '0;
            r_amt    <= '0;
            r_op     <= '0;
            r_k      <= '0;
            r_result <= '0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (ctrl_shift) begin
                        r_work  <= data_operandA;
                        r_amt   <= ctrl_shiftamt;
                        r_op    <= ctrl_shiftOp;
                        r_k     <= '0;
                        r_state <= c_SHIFT;
                    end
                end
                default: begin
                    r_work <= w_next;
                    r_k    <= r_k + SHAMT_W'(1);
                    // Every stage runs even when its amount bit is zero, so latency is fixed.
                    if (r_k == c_LAST_K) begin
                        r_result <= w_next;
                        r_rdy    <= 1'b1;
                        r_k      <= '0;
                        r_state  <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_resultRDY = r_rdy;
    assign busy           = (r_state == c_SHIFT);

endmodule
`default_nettype wire
